bias_add_unit: RTL and testbench

BIAS_ADD_UNIT -- requirements
Module: bias_add_unit

---
 rtl/bias_pkg.sv | 36 +++
 rtl/bias_regfile.sv | 38 +++
 rtl/bias_add_unit.sv | 116 +++++++++++
 tb/tb_bias_add_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared constants, channel index type and the shift/ReLU/saturate helper
// used by the bias-add stage and other layer blocks.
package bias_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_NUM_CH = 16;
    localparam int DEF_SHIFT  = 8;

    typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;

    // Works on a 64-bit sign-extended value; callers truncate to out_w bits.
    function automatic logic signed [63:0] shift_sat(
        input logic signed [63:0] val,
        input int unsigned        shift,
        input logic               relu,
        input int unsigned        out_w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = val >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (relu && (s < 64'sd0)) begin
            s = 64'sd0;
        end
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/bias_regfile.sv
// Per-channel bias storage: one synchronous write port, one combinational
// read port. A same-cycle write is not visible on the read port until next cycle.
module bias_regfile
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int AW     = $clog2(DEF_NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < NUM_CH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < NUM_CH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/bias_add_unit.sv
// Adds a per-channel bias to each accumulator beat, shifts, optionally ReLUs
// and saturates; one-cycle registered output with valid/ready backpressure.
module bias_add_unit
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      relu_en,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]         cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      err_len
);

    localparam int CH_W = $clog2(NUM_CH);

    // Handshake: a beat moves on a cycle where valid and ready are both high;
    // in_ready depends only on the output register and out_ready, never on in_valid.

    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_last_q, out_last_d;

    logic              accept;
    logic              last_ch;
    logic [DATA_W-1:0] bias_rd;
    logic signed [DATA_W:0] sum;
    logic signed [63:0]     sum_ext;
    logic [OUT_W-1:0]  result;

    bias_regfile #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .AW     (CH_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (ch_cnt_q),
        .rdata_o (bias_rd)
    );

    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_ch  = (ch_cnt_q == CH_W'(NUM_CH - 1));

    always_comb begin
        sum     = {in_data[DATA_W-1], in_data} + {bias_rd[DATA_W-1], bias_rd};
        sum_ext = {{(63 - DATA_W){sum[DATA_W]}}, sum};
        result  = OUT_W'(shift_sat(sum_ext, SHIFT, relu_en, OUT_W));
    end

    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (accept) begin
            ch_cnt_d    = (in_last || last_ch) ? '0 : ch_cnt_q + 1'b1;
            // Length error: last flag disagrees with the channel position.
            err_d       = err_q | (in_last != last_ch);
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_ch_d    = ch_cnt_q;
            out_last_d  = in_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_cnt_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_bias_add_unit.sv
// Bench for bias_add_unit: two instances (SHIFT=8 and SHIFT=0) share one
// stimulus stream; a reference model fills expected queues, a monitor drains them.
module tb_bias_add_unit;
    import bias_pkg::*;

    localparam int NC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        relu_en = 1'b0, cfg_we = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0, in_data = '0;

    logic        ir8, ov8, ol8, er8, ir0, ov0, ol0, er0;
    logic [15:0] od8, od0;
    logic [3:0]  oc8, oc0;

    bias_add_unit #(.DATA_W(32), .OUT_W(16), .NUM_CH(NC), .SHIFT(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(ir8), .in_data(in_data),
        .in_last(in_last), .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
        .out_ch(oc8), .out_last(ol8), .err_len(er8));

    bias_add_unit #(.DATA_W(32), .OUT_W(16), .NUM_CH(NC), .SHIFT(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_ch(oc0), .out_last(ol0), .err_len(er0));

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q8[$];
    logic [20:0] exp_q0[$];
    logic [31:0] bias_m [NC];
    ch_idx_t     ch_m;
    logic        err_m;
    int          ordy_mode;
    int          cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, then clamp.
    function automatic logic [15:0] ref_out(input logic [31:0] d, input logic [31:0] b,
                                            input int sh, input logic relu);
        longint s;
        logic [63:0] r;
        s = longint'($signed(d)) + longint'($signed(b));
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = 64'(s);
        return r[15:0];
    endfunction

    // Monitor: pops on each output handshake, checks hold-while-stalled.
    logic        hold8 = 1'b0, hold0 = 1'b0;
    logic [20:0] held8, held0, e8, e0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold8 = 1'b0;
            hold0 = 1'b0;
        end else begin
            check("valid_match", ov0, ov8);
            if (hold8) check("hold8", {ol8, oc8, od8}, held8);
            if (hold0) check("hold0", {ol0, oc0, od0}, held0);
            if (ov8 && !out_ready) check("stall_in_ready", ir8, 1'b0);
            if (ov8 && out_ready) begin
                checks++;
                if (exp_q8.size() == 0) begin
                    errors++;
                    $display("FAIL out8: got unexpected beat %0h, none expected", {ol8, oc8, od8});
                end else begin
                    e8 = exp_q8.pop_front();
                    checks--;
                    check("out8", {ol8, oc8, od8}, e8);
                end
            end
            if (ov0 && out_ready) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL out0: got unexpected beat %0h, none expected", {ol0, oc0, od0});
                end else begin
                    e0 = exp_q0.pop_front();
                    checks--;
                    check("out0", {ol0, oc0, od0}, e0);
                end
            end
            hold8 = ov8 && !out_ready;
            hold0 = ov0 && !out_ready;
            held8 = {ol8, oc8, od8};
            held0 = {ol0, oc0, od0};
        end
    end

    function automatic logic next_ordy();
        case (ordy_mode)
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b1;
        endcase
    endfunction

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic relu,
                         input logic we, input logic [3:0] a, input logic [31:0] wd,
                         input logic ordy, output logic acc);
        in_valid = v; in_data = d; in_last = l; relu_en = relu;
        cfg_we = we; cfg_addr = a; cfg_data = wd; out_ready = ordy;
        @(negedge clk); #1;
        check("in_ready", ir8, ordy || (exp_q8.size() == 0));
        check("in_ready_match", ir0, ir8);
        check("err_len8", er8, err_m);
        check("err_len0", er0, err_m);
        acc = v && ir8;
        if (acc) begin
            exp_q8.push_back({l, ch_m, ref_out(d, bias_m[ch_m], 8, relu)});
            exp_q0.push_back({l, ch_m, ref_out(d, bias_m[ch_m], 0, relu)});
            if (l != (ch_m == ch_idx_t'(NC - 1))) err_m = 1'b1;
            ch_m = (l || ch_m == ch_idx_t'(NC - 1)) ? '0 : ch_m + 1'b1;
        end
        if (we) bias_m[a] = wd;
        cyc++;
        @(posedge clk); #1;
    endtask

    // Sends one beat, holding it until accepted.
    task automatic beat(input logic [31:0] d, input logic relu, input logic force_last);
        logic acc;
        acc = 1'b0;
        while (!acc) cycle(1'b1, d, force_last || ch_m == ch_idx_t'(NC - 1), relu,
                           1'b0, 4'd0, 32'd0, next_ordy(), acc);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, ordy, acc);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        logic acc;
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, a, wd, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 32'h55;
        exp_q8.delete();
        exp_q0.delete();
        repeat (2) begin
            @(negedge clk); #1;
            check("rst_in_ready8", ir8, 1'b0);
            check("rst_in_ready0", ir0, 1'b0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < NC; i++) bias_m[i] = '0;
        ch_m = '0;
        err_m = 1'b0;
        rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        check("rst_state8", {ov8, er8, ol8, oc8, od8}, '0);
        check("rst_state0", {ov0, er0, ol0, oc0, od0}, '0);
        @(posedge clk); #1;
    endtask

    task automatic random_phase(input int n, input logic bad_last);
        logic        acc, v, l, we, pend;
        logic [31:0] d, wd;
        logic [3:0]  a;
        pend = 1'b0; v = 1'b0; l = 1'b0; d = '0;
        for (int i = 0; i < n; i++) begin
            if (!pend) begin
                v = $urandom_range(0, 3) != 0;
                case ($urandom_range(0, 3))
                    0:       d = 32'h7FFF_0000 + $urandom_range(0, 65535);
                    1:       d = 32'h8000_0000 + $urandom_range(0, 65535);
                    2:       d = 32'($urandom_range(0, 4095)) - 32'd2048;
                    default: d = $urandom;
                endcase
                l = (ch_m == ch_idx_t'(NC - 1)) || (bad_last && $urandom_range(0, 7) == 0);
            end
            we = $urandom_range(0, 3) == 0;
            a  = 4'($urandom_range(0, NC - 1));
            wd = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2047)) - 32'd1024;
            cycle(v, d, l, 1'($urandom_range(0, 1)), we, a, wd, next_ordy(), acc);
            pend = v && !acc;
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] b36 [NC];
        ordy_mode = 0;
        cyc = 0;
        do_reset();

        // Bias echo: zero input, every channel returns its (saturated) bias.
        b36 = '{32'h437, -32'sd66, 32'h137, 32'h0001_2345, -32'sd40000, 32'h7FFF, -32'sd32768,
                32'h1, -32'sd1, 32'h100, 32'h0, 32'h8000, -32'sd32769, 32'h7FF, -32'sd300, 32'h55AA};
        for (int i = 0; i < NC; i++) wr(4'(i), b36[i]);
        for (int i = 0; i < NC; i++) beat(32'd0, 1'b0, 1'b0);

        // Saturation corners.
        wr(4'd0, 32'h0000_0200);
        wr(4'd1, 32'hFFFF_FFFF);
        beat(32'h7FFF_FF00, 1'b0, 1'b0);
        beat(32'h8000_0000, 1'b0, 1'b0);
        while (ch_m != '0) beat($urandom, 1'b0, 1'b0);

        // ReLU on and off for -100 + 50.
        wr(4'd0, 32'd50);
        wr(4'd1, 32'd50);
        beat(-32'sd100, 1'b1, 1'b0);
        beat(-32'sd100, 1'b0, 1'b0);
        while (ch_m != '0) beat($urandom, 1'b0, 1'b0);

        // Continuous stream under the 1,0,0,1 out_ready pattern.
        ordy_mode = 1;
        for (int i = 0; i < 2 * NC; i++) beat($urandom, 1'($urandom_range(0, 1)), 1'b0);
        ordy_mode = 0;
        idle(1'b1);

        // Same-cycle write to the channel being accepted uses the old bias.
        ordy_mode = 2;
        random_phase(150, 1'b0);
        ordy_mode = 0;
        while (ch_m != ch_idx_t'(3)) beat($urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'd1000, 1'b0, 1'b0, 1'b1, 4'd3, 32'd7, 1'b1, acc);
        while (ch_m != '0) beat(32'd1000, 1'b0, 1'b0);
        for (int i = 0; i < NC; i++) beat(32'd1000, 1'b0, 1'b0);

        // Short pixel: last on channel 5 raises the sticky error.
        while (ch_m != ch_idx_t'(5)) beat($urandom, 1'b0, 1'b0);
        beat(32'd123, 1'b0, 1'b1);
        beat(32'd456, 1'b0, 1'b0);
        idle(1'b1);
        ordy_mode = 2;
        random_phase(200, 1'b1);

        // Reset mid-pixel, after channel 9.
        ordy_mode = 1;
        while (ch_m != '0) beat($urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) beat($urandom, 1'b0, 1'b0);
        do_reset();
        ordy_mode = 0;
        for (int i = 0; i < NC; i++) beat(32'd0, 1'b0, 1'b0);
        ordy_mode = 2;
        random_phase(150, 1'b1);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && (exp_q8.size() != 0 || exp_q0.size() != 0); i++) idle(1'b1);
        check("drain8", 64'(exp_q8.size()), 64'd0);
        check("drain0", 64'(exp_q0.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
